// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants and state encoding for the Mips16 program loader.
//   DEPTH      instruction-memory capacity in 16-bit words (shared with the IF stage)
//   CNT_W      word-counter width, wide enough to hold DEPTH
//   RUN_W      run-length counter width
//   PCRST_CYC  cycles for which the core's pc_reset is held high
package imem_loader_pkg;
    localparam int DEPTH     = 256;
    localparam int CNT_W     = 9;
    localparam int RUN_W     = 16;
    localparam int PCRST_CYC = 2;
    localparam int PC_W      = $clog2(PCRST_CYC + 1);

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LOAD  = 3'd1,
        LD_PCRST = 3'd2,
        LD_RUN   = 3'd3,
        LD_DONE  = 3'd4
    } ld_state_e;
endpackage

// File: rtl/imem_loader_up_down_counter.sv
// up_down_counter: loadable counter that counts one way and saturates instead of wrapping.
//   clk, reset  clock and synchronous active-high reset (count -> 0)
//   load        load_val is taken this cycle (wins over en)
//   en          count one step toward the saturation limit
//   count       current value; UP=1 saturates at all-ones, UP=0 saturates at zero
module up_down_counter #(
    parameter int W  = 8,
    parameter bit UP = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && (UP ? count != '1 : count != '0))
            count <= UP ? count + 1'b1 : count - 1'b1;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: host-side program loader and run controller for the Mips16 core.
//   start/run_len                       begin a load (IDLE/DONE only), latching the run length
//   host_valid/host_data/host_last      instruction stream in; host_ready accepts it
//   core_din/core_wen                   instruction-memory write port, one cycle after accept
//   core_pc_reset/core_rd_en/core_dout  core PC reset, run enable and write-back data
//   word_count/result/busy/done/ovf     status: words written, captured dout, phase, overflow
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RUN_W-1:0] run_len,
    input  logic             host_valid,
    input  logic [15:0]      host_data,
    input  logic             host_last,
    output logic             host_ready,
    output logic [15:0]      core_din,
    output logic             core_wen,
    output logic             core_pc_reset,
    output logic             core_rd_en,
    input  logic [15:0]      core_dout,
    output logic [CNT_W-1:0] word_count,
    output logic [15:0]      result,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    ld_state_e        state, next;
    logic [PC_W-1:0]  pc_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic             go, accept, full, last_word;

    assign host_ready = state == LD_LOAD;
    assign go         = start && (state == LD_IDLE || state == LD_DONE);
    assign accept     = host_valid && host_ready;
    // The accept that fills the memory ends the load even without host_last.
    assign full       = word_count == CNT_W'(DEPTH - 1);
    assign last_word  = accept && (host_last || full);

    // Control strobes decode straight from the state register, so they drop on the
    // first edge that sees reset and cannot pulse while it is held.
    assign core_pc_reset = state == LD_PCRST;
    assign core_rd_en    = state == LD_RUN;
    assign busy          = state == LD_LOAD || state == LD_PCRST || state == LD_RUN;
    assign done          = state == LD_DONE;

    up_down_counter #(.W(CNT_W), .UP(1'b1)) u_word_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (go),
        .load_val('0),
        .en      (accept),
        .count   (word_count)
    );

    up_down_counter #(.W(RUN_W), .UP(1'b0)) u_run_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (go),
        .load_val(run_len),
        .en      (state == LD_RUN),
        .count   (run_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= LD_IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            LD_IDLE, LD_DONE: next = go ? LD_LOAD : state;
            LD_LOAD:          next = last_word ? LD_PCRST : state;
            LD_PCRST:         next = pc_cnt != PC_W'(PCRST_CYC - 1) ? state :
                                     run_cnt == '0 ? LD_DONE : LD_RUN;
            LD_RUN:           next = run_cnt <= RUN_W'(1) ? LD_DONE : state;
            default:          next = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_din <= '0;
            core_wen <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
            pc_cnt   <= '0;
        end else begin
            core_wen <= accept;
            if (accept)
                core_din <= host_data;
            pc_cnt <= state == LD_PCRST ? pc_cnt + 1'b1 : '0;
            if (go)
                ovf <= 1'b0;
            else if (accept && !host_last && full)
                ovf <= 1'b1;
            // run_cnt==1 marks the final RUN cycle.
            if (state == LD_RUN && run_cnt == RUN_W'(1))
                result <= core_dout;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; accepted words are queued and
// compared against every core_wen write seen by a separate monitor.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [RUN_W-1:0] run_len = '0;
    logic             host_valid = 1'b0;
    logic [15:0]      host_data = '0;
    logic             host_last = 1'b0;
    logic             host_ready;
    logic [15:0]      core_din;
    logic             core_wen;
    logic             core_pc_reset;
    logic             core_rd_en;
    logic [15:0]      core_dout = '0;
    logic [CNT_W-1:0] word_count;
    logic [15:0]      result;
    logic             busy;
    logic             done;
    logic             ovf;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .run_len      (run_len),
        .host_valid   (host_valid),
        .host_data    (host_data),
        .host_last    (host_last),
        .host_ready   (host_ready),
        .core_din     (core_din),
        .core_wen     (core_wen),
        .core_pc_reset(core_pc_reset),
        .core_rd_en   (core_rd_en),
        .core_dout    (core_dout),
        .word_count   (word_count),
        .result       (result),
        .busy         (busy),
        .done         (done),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    int n_chk = 0, n_pass = 0;
    int wen_tot = 0, pc_tot = 0, rd_tot = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest accepted word.
    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (core_wen) begin
                wen_tot++;
                if (exp_q.size() == 0) chk("wen_unexpected", {16'h0, core_din}, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("wen_din", {16'h0, core_din}, {16'h0, e});
                end
            end
            if (core_pc_reset) pc_tot++;
            if (core_rd_en) rd_tot++;
        end
    endtask

    task automatic pulse_start(input logic [RUN_W-1:0] rl);
        start = 1'b1;
        run_len = rl;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one word and hold it until the loader takes it; host_valid stays high.
    task automatic send(input logic [15:0] d, input logic l);
        int k = 0;
        logic acc;
        host_valid = 1'b1;
        host_data = d;
        host_last = l;
        do begin
            @(negedge clk);
            acc = host_ready;
            if (acc) exp_q.push_back(d);
            @(posedge clk); #1;
            k++;
        end while (!acc && k < 20);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 2000);
        chk("done_reached", {31'h0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rd();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!core_rd_en && k < 100);
        chk("rd_en_reached", {31'h0, core_rd_en}, 32'd1);
    endtask

    initial begin
        int w0, p0, r0, acc;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_word_count", {23'h0, word_count}, 32'd0);
        chk("rst_flags", {26'h0, busy, done, ovf, core_wen, core_pc_reset, core_rd_en}, 32'd0);
        chk("rst_result_din", {result, core_din}, 32'd0);
        chk("rst_host_ready", {31'h0, host_ready}, 32'd0);
        @(posedge clk); #1;

        // 1: four words, run three cycles
        w0 = wen_tot; p0 = pc_tot; r0 = rd_tot;
        pulse_start(3);
        chk("t1_busy", {31'h0, busy}, 32'd1);
        send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 1);
        host_valid = 1'b0;
        wait_done();
        chk("t1_wen_cnt", wen_tot - w0, 32'd4);
        chk("t1_pcrst_cnt", pc_tot - p0, 32'd2);
        chk("t1_rd_cnt", rd_tot - r0, 32'd3);
        chk("t1_word_count", {23'h0, word_count}, 32'd4);
        chk("t1_done", {30'h0, done, busy}, 32'd2);

        // 2: host stall between two words
        w0 = wen_tot;
        pulse_start(1);
        send(16'hA5A5, 0);
        host_valid = 1'b0;
        @(posedge clk); #1;
        send(16'h5A5A, 1);
        host_valid = 1'b0;
        wait_done();
        chk("t2_wen_cnt", wen_tot - w0, 32'd2);
        chk("t2_word_count", {23'h0, word_count}, 32'd2);
        chk("t2_ovf", {31'h0, ovf}, 32'd0);

        // 3: 257 words offered without last
        w0 = wen_tot; p0 = pc_tot; acc = 0;
        pulse_start(1);
        for (int i = 0; i < 257; i++) begin
            host_valid = 1'b1;
            host_data = 16'h8000 + 16'(i);
            host_last = 1'b0;
            @(negedge clk);
            if (host_ready) begin
                exp_q.push_back(host_data);
                acc++;
            end
            @(posedge clk); #1;
        end
        host_valid = 1'b0;
        chk("t3_accepted", acc, 32'd256);
        chk("t3_ovf", {31'h0, ovf}, 32'd1);
        chk("t3_ready_low", {31'h0, host_ready}, 32'd0);
        wait_done();
        chk("t3_wen_cnt", wen_tot - w0, 32'd256);
        chk("t3_pcrst_cnt", pc_tot - p0, 32'd2);
        chk("t3_word_count", {23'h0, word_count}, 32'd256);

        // 4: zero run length skips RUN
        r0 = rd_tot;
        pulse_start(0);
        chk("t4_ovf_cleared", {31'h0, ovf}, 32'd0);
        send(16'h0F0F, 1);
        host_valid = 1'b0;
        @(negedge clk);
        chk("t4_pcrst_c1", {30'h0, core_pc_reset, done}, 32'd2);
        @(negedge clk);
        chk("t4_pcrst_c2", {30'h0, core_pc_reset, done}, 32'd2);
        @(negedge clk);
        chk("t4_done_c3", {30'h0, core_pc_reset, done}, 32'd1);
        @(posedge clk); #1;
        chk("t4_rd_cnt", rd_tot - r0, 32'd0);

        // 6: result capture on the final RUN cycle; stray starts ignored
        r0 = rd_tot;
        pulse_start(3);
        send(16'h1234, 0);
        host_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send(16'h5678, 1);
        host_valid = 1'b0;
        wait_rd();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t6_rd_c3", {31'h0, core_rd_en}, 32'd1);
        core_dout = 16'hBEEF;
        @(negedge clk);
        core_dout = 16'h0000;
        chk("t6_done", {31'h0, done}, 32'd1);
        chk("t6_result", {16'h0, result}, 32'h0000_BEEF);
        chk("t6_word_count", {23'h0, word_count}, 32'd2);
        @(posedge clk); #1;
        chk("t6_rd_cnt", rd_tot - r0, 32'd3);

        // 5: reset during RUN
        pulse_start(10);
        send(16'h7777, 1);
        host_valid = 1'b0;
        wait_rd();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rd_en", {31'h0, core_rd_en}, 32'd0);
        chk("t5_state_idle", {29'h0, busy, done, host_ready}, 32'd0);
        chk("t5_result", {16'h0, result}, 32'd0);
        chk("t5_word_count", {23'h0, word_count}, 32'd0);
        chk("t5_queue_empty", exp_q.size(), 32'd0);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
